// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and FSM state type for the ALU arbiter
package alu_pkg;

   localparam int OP_W    = 2;
   localparam int FLAGS_W = 5;
   localparam int CNT_W   = 3;

   localparam int FLAG_GT  = 0;
   localparam int FLAG_LT  = 1;
   localparam int FLAG_EQ  = 2;
   localparam int FLAG_PAR = 3;
   localparam int FLAG_OVF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if #(
   parameter int DATA_W = 8
);
   import alu_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_y;
   logic              alu_greater;
   logic              alu_less;
   logic              alu_is_eq;
   logic              alu_parity;
   logic              alu_overflow;

   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [DATA_W-1:0]  rsp_y;
   logic [FLAGS_W-1:0] rsp_flags;

   // requesters, ALU and response consumer
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_op, alu_a, alu_b,
      output alu_y, alu_greater, alu_less, alu_is_eq, alu_parity, alu_overflow,
      input  rsp_valid, rsp_id, rsp_y, rsp_flags,
      output rsp_ready
   );

   // the arbiter itself
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_op, alu_a, alu_b,
      input  alu_y, alu_greater, alu_less, alu_is_eq, alu_parity, alu_overflow,
      output rsp_valid, rsp_id, rsp_y, rsp_flags,
      input  rsp_ready
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin grant with priority pointer
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       enable,
   output logic       grant_valid,
   output logic       grant_id
);

   logic prio;

   // grant the preferred requester on contention, otherwise whoever is asking
   always_comb begin
      grant_valid = enable && (req != 2'b00);
      grant_id    = (req == 2'b11) ? prio : req[1];
   end

   // after a grant the other requester becomes preferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (grant_valid) begin
         prio <= ~grant_id;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one multi-cycle ALU between two requesters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ALU_LAT = 1
) (
   input logic         clk,
   input logic         rst_n,
   alu_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [OP_W-1:0]    op_q;
   logic [DATA_W-1:0]  a_q;
   logic [DATA_W-1:0]  b_q;
   logic               id_q;
   logic [DATA_W-1:0]  rsp_y_q;
   logic [FLAGS_W-1:0] rsp_flags_q;
   logic [FLAGS_W-1:0] flags_in;
   logic               grant_en;
   logic               grant_valid;
   logic               grant_id;

   // gated by rst_n so ready stays low while reset is held
   assign grant_en = rst_n && (state_q == IDLE);

   rr_arb2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         ({bus.req1_valid, bus.req0_valid}),
      .enable      (grant_en),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign bus.req0_ready = grant_valid && !grant_id;
   assign bus.req1_ready = grant_valid &&  grant_id;

   assign bus.alu_op = op_q;
   assign bus.alu_a  = a_q;
   assign bus.alu_b  = b_q;

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_flags = rsp_flags_q;

   // gather ALU flags into the response bit order
   always_comb begin
      flags_in           = '0;
      flags_in[FLAG_GT]  = bus.alu_greater;
      flags_in[FLAG_LT]  = bus.alu_less;
      flags_in[FLAG_EQ]  = bus.alu_is_eq;
      flags_in[FLAG_PAR] = bus.alu_parity;
      flags_in[FLAG_OVF] = bus.alu_overflow;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state: grant -> wait ALU_LAT cycles -> hold response until taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ALU latency counter, loaded on grant and counted down in EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (grant_valid) begin
         cnt_q <= LAT_M1;
      end else if (state_q == EXEC && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // capture the granted operation; ALU drive holds these until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         id_q <= 1'b0;
      end else if (grant_valid) begin
         op_q <= grant_id ? bus.req1_op : bus.req0_op;
         a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
         b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
         id_q <= grant_id;
      end
   end

   // sample the ALU result when its latency has elapsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_y_q     <= '0;
         rsp_flags_q <= '0;
      end else if (state_q == EXEC && cnt_q == '0) begin
         rsp_y_q     <= bus.alu_y;
         rsp_flags_q <= flags_in;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter at ALU_LAT 1 and 3
module tb_alu_arbiter;

   typedef struct packed {
      logic       id;
      logic [7:0] y;
      logic [4:0] flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   gcyc_a = 0;
   int   gcyc_b = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   alu_arbiter_if #(.DATA_W(8)) ia ();
   alu_arbiter_if #(.DATA_W(8)) ib ();

   alu_arbiter #(.DATA_W(8), .ALU_LAT(1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia));
   alu_arbiter #(.DATA_W(8), .ALU_LAT(3)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU: 0 add (carry->ovf), 1 sub (borrow->ovf), 2 and, 3 xor
   function automatic logic [12:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] y;
      logic       ovf;
      s = 9'd0;
      case (op)
         2'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; ovf = s[8]; end
         2'd1: begin y = a - b; ovf = (a < b); end
         2'd2: begin y = a & b; ovf = 1'b0; end
         default: begin y = a ^ b; ovf = 1'b0; end
      endcase
      return {ovf, ^y, (a == b), (a < b), (a > b), y};
   endfunction

   assign {ia.alu_overflow, ia.alu_parity, ia.alu_is_eq, ia.alu_less, ia.alu_greater, ia.alu_y} =
      alu_model(ia.alu_op, ia.alu_a, ia.alu_b);
   assign {ib.alu_overflow, ib.alu_parity, ib.alu_is_eq, ib.alu_less, ib.alu_greater, ib.alu_y} =
      alu_model(ib.alu_op, ib.alu_a, ib.alu_b);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs_a();
      return {29'd0, ia.req0_ready, ia.req1_ready, ia.rsp_valid, ia.rsp_id, ia.rsp_y,
              ia.rsp_flags, ia.alu_op, ia.alu_a, ia.alu_b};
   endfunction

   // monitor for the ALU_LAT=1 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst_a) begin
         prev_a = 1'b0;
      end else begin
         if ((ia.req0_valid && ia.req0_ready) || (ia.req1_valid && ia.req1_ready)) gcyc_a = cyc;
         if (ia.rsp_valid) begin
            check("a_no_ready_in_resp", {ia.req0_ready, ia.req1_ready}, 0);
            if (!prev_a) check("a_latency", cyc - gcyc_a, 2);
            if (ia.rsp_ready) begin
               check("a_rsp_expected", q_a.size() != 0, 1);
               if (q_a.size() != 0) begin
                  e = q_a.pop_front();
                  check("a_rsp_id", ia.rsp_id, e.id);
                  check("a_rsp_y", ia.rsp_y, e.y);
                  check("a_rsp_flags", ia.rsp_flags, e.flags);
               end
            end
         end
         prev_a = ia.rsp_valid;
      end
   end

   // monitor for the ALU_LAT=3 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst_b) begin
         prev_b = 1'b0;
      end else begin
         if ((ib.req0_valid && ib.req0_ready) || (ib.req1_valid && ib.req1_ready)) gcyc_b = cyc;
         if (ib.rsp_valid) begin
            check("b_no_ready_in_resp", {ib.req0_ready, ib.req1_ready}, 0);
            if (!prev_b) check("b_latency", cyc - gcyc_b, 4);
            if (ib.rsp_ready) begin
               check("b_rsp_expected", q_b.size() != 0, 1);
               if (q_b.size() != 0) begin
                  e = q_b.pop_front();
                  check("b_rsp_id", ib.rsp_id, e.id);
                  check("b_rsp_y", ib.rsp_y, e.y);
                  check("b_rsp_flags", ib.rsp_flags, e.flags);
               end
            end
         end
         prev_b = ib.rsp_valid;
      end
   end

   task automatic issue_a(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      logic got = 1'b0;
      int   n = 0;
      if (id) begin ia.req1_op = op; ia.req1_a = a; ia.req1_b = b; ia.req1_valid = 1'b1; end
      else    begin ia.req0_op = op; ia.req0_a = a; ia.req0_b = b; ia.req0_valid = 1'b1; end
      while (n < 20 && !got) begin
         @(negedge clk);
         got = id ? ia.req1_ready : ia.req0_ready;
         n++;
      end
      check("a_grant_seen", got, 1);
      @(posedge clk); #1;
      ia.req0_valid = 1'b0;
      ia.req1_valid = 1'b0;
   endtask

   task automatic drain_a();
      int n = 0;
      while (n < 50 && (q_a.size() != 0 || ia.rsp_valid)) begin @(posedge clk); #1; n++; end
      check("a_drain", q_a.size(), 0);
   endtask

   task automatic drain_b();
      int n = 0;
      while (n < 50 && (q_b.size() != 0 || ib.rsp_valid)) begin @(posedge clk); #1; n++; end
      check("b_drain", q_b.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   g;
      logic got;
      rst_a = 1'b0; rst_b = 1'b0;
      {ia.req0_valid, ia.req0_op, ia.req0_a, ia.req0_b} = '0;
      {ia.req1_valid, ia.req1_op, ia.req1_a, ia.req1_b} = '0;
      {ib.req0_valid, ib.req0_op, ib.req0_a, ib.req0_b} = '0;
      {ib.req1_valid, ib.req1_op, ib.req1_a, ib.req1_b} = '0;
      ia.rsp_ready = 1'b1;
      ib.rsp_ready = 1'b0;

      // reset state, even with a request pending
      repeat (2) @(posedge clk);
      #1 ia.req0_valid = 1'b1;
      #1 check("a_reset_outputs", outs_a(), 0);
      check("b_reset_outputs", {ib.req0_ready, ib.req1_ready, ib.rsp_valid, ib.rsp_y, ib.alu_a}, 0);
      ia.req0_valid = 1'b0;
      @(posedge clk); #1;
      rst_a = 1'b1; rst_b = 1'b1;
      @(posedge clk); #1;

      // single add from requester 0
      q_a.push_back('{id: 1'b0, y: 8'h08, flags: 5'b01001});
      issue_a(1'b0, 2'd0, 8'h05, 8'h03);
      drain_a();

      // compare from requester 1: less only
      q_a.push_back('{id: 1'b1, y: 8'h30, flags: 5'b00010});
      issue_a(1'b1, 2'd3, 8'h10, 8'h20);
      drain_a();
      check("a_alu_hold_idle", {ia.alu_op, ia.alu_a, ia.alu_b}, {2'd3, 8'h10, 8'h20});

      // both valid continuously: grants alternate 0,1,0,1
      q_a.push_back('{id: 1'b0, y: 8'h00, flags: 5'b10001});
      q_a.push_back('{id: 1'b1, y: 8'hFC, flags: 5'b10010});
      q_a.push_back('{id: 1'b0, y: 8'h00, flags: 5'b10001});
      q_a.push_back('{id: 1'b1, y: 8'hFC, flags: 5'b10010});
      ia.req0_op = 2'd0; ia.req0_a = 8'hFF; ia.req0_b = 8'h01;
      ia.req1_op = 2'd1; ia.req1_a = 8'h03; ia.req1_b = 8'h07;
      ia.req0_valid = 1'b1; ia.req1_valid = 1'b1;
      g = 0; n = 0;
      while (g < 4 && n < 100) begin
         @(negedge clk);
         if (ia.req0_ready || ia.req1_ready) g++;
         n++;
      end
      check("a_alternating_grants", g, 4);
      @(posedge clk); #1;
      ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
      drain_a();

      // reset in the middle of EXEC discards the operation
      issue_a(1'b0, 2'd0, 8'h01, 8'h02);
      rst_a = 1'b0;
      #1 check("a_reset_mid_exec", outs_a(), 0);
      ia.req1_op = 2'd2; ia.req1_a = 8'hAA; ia.req1_b = 8'h0F; ia.req1_valid = 1'b1;
      q_a.push_back('{id: 1'b1, y: 8'h0A, flags: 5'b00001});
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b1;
      #1 check("a_grant_after_release", {ia.req1_ready, ia.rsp_valid}, 2'b10);
      @(posedge clk); #1;
      ia.req1_valid = 1'b0;
      drain_a();

      // ALU_LAT=3 with response back-pressure; requester 1 waiting throughout
      q_b.push_back('{id: 1'b0, y: 8'h30, flags: 5'b00001});
      q_b.push_back('{id: 1'b1, y: 8'h02, flags: 5'b01100});
      ib.req0_op = 2'd2; ib.req0_a = 8'hF0; ib.req0_b = 8'h3C;
      ib.req1_op = 2'd0; ib.req1_a = 8'h01; ib.req1_b = 8'h01;
      ib.req0_valid = 1'b1; ib.req1_valid = 1'b1;
      got = 1'b0; n = 0;
      while (n < 20 && !got) begin @(negedge clk); got = ib.req0_ready; n++; end
      check("b_grant0_seen", got, 1);
      @(posedge clk); #1;
      ib.req0_valid = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (ib.rsp_valid) break;
         check("b_ready_low_exec", {ib.req0_ready, ib.req1_ready}, 0);
         n++;
      end
      check("b_rsp_valid_seen", ib.rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("b_rsp_stable", {ib.rsp_valid, ib.rsp_id, ib.rsp_y, ib.rsp_flags, ib.req0_ready, ib.req1_ready},
               {1'b1, 1'b0, 8'h30, 5'b00001, 2'b00});
         check("b_alu_stable", {ib.alu_op, ib.alu_a, ib.alu_b}, {2'd2, 8'hF0, 8'h3C});
         @(negedge clk);
      end
      @(posedge clk); #1;
      ib.rsp_ready = 1'b1;
      got = 1'b0; n = 0;
      while (n < 20 && !got) begin @(negedge clk); got = ib.req1_ready; n++; end
      check("b_grant1_seen", got, 1);
      @(posedge clk); #1;
      ib.req1_valid = 1'b0;
      drain_b();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width.
REQ-002 Parameter ALU_LAT, default 1, legal 1..7: cycles from operand drive to valid ALU result.
REQ-003 Port clk  in  1: single clock, all state on rising edge.
REQ-004 Port rst_n  in  1: asynchronous active-low reset.
REQ-005 Ports req0_valid / req1_valid  in  1: requester 0/1 has an operation pending.
REQ-006 Ports req0_ready / req1_ready  out  1: request accepted this cycle when valid&&ready.
REQ-007 Ports req0_op / req1_op  in  2: ALU opcode; passed through unmodified.
REQ-008 Ports req0_a, req0_b, req1_a, req1_b  in  DATA_W: operands.
REQ-009 Ports alu_op  out  2; alu_a, alu_b  out  DATA_W: drive of the shared ALU.
REQ-010 Ports alu_y  in  DATA_W; alu_greater, alu_less, alu_is_eq, alu_parity, alu_overflow  in  1: ALU results.
REQ-011 Port rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-012 Port rsp_id  out  1: requester that owns the response.
REQ-013 Ports rsp_y  out  DATA_W; rsp_flags  out  5, order {overflow, parity, is_eq, less, greater}.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; exactly one ALU operation in flight.
REQ-015 IDLE: if any reqN_valid, grant one, assert that reqN_ready combinationally that cycle, latch op/a/b and id, go EXEC.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester.
REQ-017 Arbitration round-robin: pointer prio (reset 0) names preferred requester; on both valid, grant prio; after any grant prio = ~granted id.
REQ-018 Single valid requester is granted regardless of prio.
REQ-019 alu_op/alu_a/alu_b SHALL come from the latched registers, stable from entry to EXEC until exit from RESP; in IDLE they SHALL hold last values.
REQ-020 EXEC: 3-bit counter loads ALU_LAT-1 on entry, decrements each cycle; at count 0 sample alu_y and flags into rsp registers, go RESP.
REQ-021 Grant-to-rsp_valid latency SHALL be ALU_LAT+1 cycles.
REQ-022 RESP: rsp_valid=1; rsp_id/rsp_y/rsp_flags stable; on rsp_ready go IDLE.
REQ-023 RESP exit and next grant SHALL NOT occur in the same cycle (one IDLE cycle between operations).
REQ-024 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-025 Requester dropping valid without handshake SHALL have no effect; arbiter does not check it.
REQ-026 No arithmetic on data; widths pass through unchanged.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, prio=0, counter=0, all ready/rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0, alu_op=0, alu_a=0, alu_b=0.
REQ-028 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response emitted after release.
REQ-029 First grant possible in the first clock edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg holds: opcode width constant (2), flag index constants (GT=0, LT=1, EQ=2, PAR=3, OVF=4), FSM state enum.
REQ-031 One sub-module rr_arb2 (2-way round-robin grant with prio register); the rest is flat in alu_arbiter.

Verification
REQ-032 Single req0: op=0, a=8'h05, b=8'h03, ALU_LAT=1, ALU model y=8'h08 -> rsp_valid 2 cycles after grant, rsp_id=0, rsp_y=8'h08.
REQ-033 req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; prio toggles after each.
REQ-034 ALU_LAT=3, rsp_ready held 0 for 5 cycles -> rsp_valid at grant+4, rsp fields stable; ready=0 to both requesters throughout.
REQ-035 Compare a=8'h10, b=8'h20 -> rsp_flags=5'b00010 (less only), copied from ALU model.
REQ-036 rst_n low during EXEC -> all outputs zero asynchronously; after release no rsp_valid until a new grant.
REQ-037 rsp_ready=1 in same cycle both requesters valid -> no grant that cycle; grant on the following cycle.
